adc5g_gray_pattern_gen: RTL and testbench

Test-pattern transmitter for the ADC5G demux capture path. It generates binary sample patterns (constant, ramp, PRBS, alternating) and converts each sample to Gray code (g = b ^ (b >> 1)). It presents NUM_SAMPLES packed samples per word on a valid/ready stream. It is the encoding counterpart of the capture-side Gray-to-binary decode and drives loopback and bench checks of the dmux interface.

---
 rtl/adc5g_gray_pattern_gen_pkg.sv | 31 +++
 rtl/adc5g_gray_pattern_gen_bin2gc.sv | 13 +
 rtl/adc5g_gray_pattern_gen.sv | 155 +++++++++++++++
 tb/tb_adc5g_gray_pattern_gen.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc5g_gray_pattern_gen_pkg.sv
// Shared encodings and LFSR helpers for the ADC5G Gray-coded test-pattern transmitter.
package adc5g_gray_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_CONST = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_PRBS  = 2'd2,
    MODE_ALT   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps for x^16+x^14+x^13+x^11+1 in a right-shifting register
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

  function automatic logic [15:0] rotl16(input logic [15:0] v, input int unsigned n);
    logic [31:0] d;
    d = {v, v} << (n % 16);
    return d[31:16];
  endfunction

endpackage

// File: rtl/adc5g_gray_pattern_gen_bin2gc.sv
// Binary to Gray encoder; inverse of the capture-side Gray decoder.
module adc5g_gray_pattern_gen_bin2gc
  import adc5g_gray_pattern_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] bin,
  output logic [DATA_WIDTH-1:0] gc
);

  assign gc = bin ^ (bin >> 1);

endmodule

// File: rtl/adc5g_gray_pattern_gen.sv
// Test-pattern transmitter: binary constant/ramp/PRBS/alternating samples,
// Gray-encoded and packed NUM_SAMPLES per word on a valid/ready stream.
module adc5g_gray_pattern_gen
  import adc5g_gray_pattern_gen_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_SAMPLES = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              stop,
  input  logic [1:0]                        mode,
  input  logic [DATA_WIDTH-1:0]             const_val,
  input  logic [CNT_WIDTH-1:0]              burst_len,
  output logic [NUM_SAMPLES*DATA_WIDTH-1:0] gc_data,
  output logic                              gc_valid,
  input  logic                              gc_ready,
  output logic                              busy,
  output logic                              done,
  output logic [CNT_WIDTH-1:0]              word_cnt
);

  localparam int WW = NUM_SAMPLES * DATA_WIDTH;

  state_t                  state;
  mode_t                   mode_r;
  logic [DATA_WIDTH-1:0]   const_r;
  logic [CNT_WIDTH-1:0]    len_r;
  logic [DATA_WIDTH-1:0]   base;
  logic [15:0]             lfsr;
  logic                    odd;

  logic                    xfer;
  logic                    start_acc;
  logic                    last;
  logic [CNT_WIDTH-1:0]    cnt_inc;

  mode_t                   nmode;
  logic [DATA_WIDTH-1:0]   nconst;
  logic [DATA_WIDTH-1:0]   nbase;
  logic [15:0]             nlfsr;
  logic                    nodd;
  logic [WW-1:0]           bin_word;
  logic [WW-1:0]           gc_next;

  assign xfer      = gc_valid & gc_ready;
  assign start_acc = (state == IDLE) & start;
  assign last      = (len_r != '0) && ((word_cnt + CNT_WIDTH'(1)) == len_r);
  assign cnt_inc   = (&word_cnt) ? word_cnt : word_cnt + CNT_WIDTH'(1);

  // Generator state for the word being loaded: fresh on start, advanced on transfer
  always_comb begin
    nmode  = mode_r;
    nconst = const_r;
    nbase  = base + DATA_WIDTH'(NUM_SAMPLES);
    nlfsr  = lfsr_step(lfsr);
    nodd   = ~odd;
    if (start_acc) begin
      nmode  = mode_t'(mode);
      nconst = const_val;
      nbase  = '0;
      nlfsr  = LFSR_SEED;
      nodd   = 1'b0;
    end
  end

  always_comb begin
    bin_word = '0;
    for (int i = 0; i < NUM_SAMPLES; i++) begin
      case (nmode)
        MODE_CONST: bin_word[i*DATA_WIDTH +: DATA_WIDTH] = nconst;
        MODE_RAMP:  bin_word[i*DATA_WIDTH +: DATA_WIDTH] = nbase + DATA_WIDTH'(i);
        MODE_PRBS:  bin_word[i*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(rotl16(nlfsr, i));
        default:    bin_word[i*DATA_WIDTH +: DATA_WIDTH] = nodd ? ~nconst : nconst;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SAMPLES; g++) begin : g_enc
    adc5g_gray_pattern_gen_bin2gc #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_bin2gc (
      .bin(bin_word[g*DATA_WIDTH +: DATA_WIDTH]),
      .gc (gc_next[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mode_r   <= MODE_CONST;
      const_r  <= '0;
      len_r    <= '0;
      base     <= '0;
      lfsr     <= LFSR_SEED;
      odd      <= 1'b0;
      gc_data  <= '0;
      gc_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      word_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_r   <= nmode;
            const_r  <= nconst;
            len_r    <= burst_len;
            base     <= nbase;
            lfsr     <= nlfsr;
            odd      <= nodd;
            word_cnt <= '0;
            gc_data  <= gc_next;
            gc_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            word_cnt <= cnt_inc;
            // Burst end and stop collapse into a single done pulse
            if (last || stop) begin
              gc_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              base    <= nbase;
              lfsr    <= nlfsr;
              odd     <= nodd;
              gc_data <= gc_next;
            end
          end else if (stop) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (xfer) begin
            word_cnt <= cnt_inc;
            gc_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc5g_gray_pattern_gen.sv
// Directed self-checking bench for adc5g_gray_pattern_gen (8-bit samples, 4 per word).
module tb_adc5g_gray_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [7:0]  const_val;
  logic [15:0] burst_len;
  logic [31:0] gc_data;
  logic        gc_valid;
  logic        gc_ready;
  logic        busy;
  logic        done;
  logic [15:0] word_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  adc5g_gray_pattern_gen #(
    .DATA_WIDTH(8),
    .NUM_SAMPLES(4),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .mode(mode),
    .const_val(const_val),
    .burst_len(burst_len),
    .gc_data(gc_data),
    .gc_valid(gc_valid),
    .gc_ready(gc_ready),
    .busy(busy),
    .done(done),
    .word_cnt(word_cnt)
  );

  function automatic logic [7:0] gray8(input logic [7:0] b);
    return b ^ {1'b0, b[7:1]};
  endfunction

  function automatic logic [31:0] ramp_word(input int k);
    logic [31:0] w;
    logic [7:0]  b;
    for (int i = 0; i < 4; i++) begin
      b = 8'((k * 4 + i) % 256);
      w[i*8 +: 8] = gray8(b);
    end
    return w;
  endfunction

  function automatic logic [15:0] ref_lfsr_next(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  function automatic logic [31:0] prbs_word(input logic [15:0] l);
    logic [31:0] w;
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r = (i == 0) ? l : ((l << i) | (l >> (16 - i)));
      w[i*8 +: 8] = gray8(r[7:0]);
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [7:0] cv, input logic [15:0] bl);
    mode = m; const_val = cv; burst_len = bl; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; stop = 0; mode = 0; const_val = 0; burst_len = 0; gc_ready = 0;
    #12;
    vectors++;
    if ({gc_data, gc_valid, busy, done, word_cnt} !== 51'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%h v=%b busy=%b done=%b cnt=%0d, want all zero",
               gc_data, gc_valid, busy, done, word_cnt);
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ramp_burst();
    gc_ready = 1'b1;
    do_start(2'd1, 8'h00, 16'd2);
    vectors++;
    if (gc_data !== 32'h02030100 || gc_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ramp_word0: got %h v=%b busy=%b, want 02030100 v=1 busy=1", gc_data, gc_valid, busy);
    end
    tick();
    vectors++;
    if (gc_data !== 32'h04050706 || word_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL ramp_word1: got %h cnt=%0d, want 04050706 cnt=1", gc_data, word_cnt);
    end
    tick();
    vectors++;
    if (done !== 1'b1 || gc_valid !== 1'b0 || busy !== 1'b0 || word_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL ramp_end: got done=%b v=%b busy=%b cnt=%0d, want 1 0 0 2", done, gc_valid, busy, word_cnt);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || word_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL ramp_done_pulse: got done=%b cnt=%0d, want done=0 cnt=2", done, word_cnt);
    end
  endtask

  task automatic test_ramp_wrap();
    int bad;
    bad = 0;
    gc_ready = 1'b1;
    do_start(2'd1, 8'h00, 16'd65);
    for (int k = 0; k < 65; k++) begin
      vectors++;
      if (gc_data !== ramp_word(k) || gc_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL wrap_word%0d: got %h v=%b, want %h v=1", k, gc_data, gc_valid, ramp_word(k));
      end
      if (k == 63) begin
        vectors++;
        if (gc_data !== 32'h80818382) begin
          miscompares++;
          $display("FAIL wrap_word63_const: got %h, want 80818382", gc_data);
        end
      end
      if (k == 64) begin
        vectors++;
        if (gc_data !== 32'h02030100) begin
          miscompares++;
          $display("FAIL wrap_word64_const: got %h, want 02030100", gc_data);
        end
      end
      tick();
    end
    vectors++;
    if (done !== 1'b1 || gc_valid !== 1'b0 || word_cnt !== 16'd65) begin
      miscompares++;
      $display("FAIL wrap_end: got done=%b v=%b cnt=%0d, want 1 0 65", done, gc_valid, word_cnt);
    end
    tick();
  endtask

  task automatic test_const_stall();
    int xfers, dones;
    logic [31:0] prev;
    logic pre;
    xfers = 0; dones = 0;
    do_start(2'd0, 8'h3C, 16'd3);
    prev = gc_data;
    for (int c = 0; c < 15; c++) begin
      gc_ready = (c % 3 == 0);
      pre = gc_valid & gc_ready;
      tick();
      if (pre) xfers++;
      if (done) dones++;
      if (gc_valid) begin
        vectors++;
        if (gc_data !== 32'h22222222 || (!pre && gc_data !== prev)) begin
          miscompares++;
          $display("FAIL const_word_c%0d: got %h prev=%h, want 22222222 stable", c, gc_data, prev);
        end
        prev = gc_data;
      end
    end
    vectors++;
    if (xfers != 3 || dones != 1 || word_cnt !== 16'd3 || gc_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL const_totals: got xfers=%0d dones=%0d cnt=%0d v=%b, want 3 1 3 0",
               xfers, dones, word_cnt, gc_valid);
    end
  endtask

  task automatic test_prbs_flush();
    logic [15:0] l;
    l = 16'hACE1;
    gc_ready = 1'b1;
    do_start(2'd2, 8'h00, 16'd0);
    vectors++;
    if (gc_data !== prbs_word(l)) begin
      miscompares++;
      $display("FAIL prbs_word0: got %h, want %h", gc_data, prbs_word(l));
    end
    for (int j = 1; j <= 4; j++) begin
      tick();
      l = ref_lfsr_next(l);
      vectors++;
      if (gc_data !== prbs_word(l) || gc_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL prbs_word%0d: got %h, want %h", j, gc_data, prbs_word(l));
      end
    end
    gc_ready = 1'b0; stop = 1'b1;
    tick();
    tick();
    vectors++;
    if (gc_data !== prbs_word(l) || gc_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || word_cnt !== 16'd4) begin
      miscompares++;
      $display("FAIL prbs_flush_hold: got %h v=%b busy=%b done=%b cnt=%0d, want %h 1 1 0 4",
               gc_data, gc_valid, busy, done, word_cnt, prbs_word(l));
    end
    stop = 1'b0; gc_ready = 1'b1;
    tick();
    vectors++;
    if (done !== 1'b1 || gc_valid !== 1'b0 || busy !== 1'b0 || word_cnt !== 16'd5) begin
      miscompares++;
      $display("FAIL prbs_flush_end: got done=%b v=%b busy=%b cnt=%0d, want 1 0 0 5", done, gc_valid, busy, word_cnt);
    end
    tick();
  endtask

  task automatic test_alt();
    logic [31:0] exp;
    gc_ready = 1'b1;
    do_start(2'd3, 8'h0F, 16'd0);
    for (int k = 0; k < 6; k++) begin
      exp = (k % 2 == 0) ? 32'h08080808 : 32'h88888888;
      vectors++;
      if (gc_data !== exp) begin
        miscompares++;
        $display("FAIL alt_word%0d: got %h, want %h", k, gc_data, exp);
      end
      if (k == 2) begin
        start = 1'b1; mode = 2'd1; const_val = 8'h00;
      end
      tick();
      start = 1'b0;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    vectors++;
    if (done !== 1'b1 || gc_valid !== 1'b0 || word_cnt !== 16'd7) begin
      miscompares++;
      $display("FAIL alt_stop: got done=%b v=%b cnt=%0d, want 1 0 7", done, gc_valid, word_cnt);
    end
    tick();
  endtask

  task automatic test_async_reset();
    gc_ready = 1'b1;
    do_start(2'd1, 8'h00, 16'd0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (gc_valid !== 1'b0 || busy !== 1'b0 || word_cnt !== 16'd0 || done !== 1'b0 || gc_data !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b busy=%b cnt=%0d done=%b data=%h, want all zero",
               gc_valid, busy, word_cnt, done, gc_data);
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_nodone: got done=%b, want 0", done);
    end
    #2 rst_n = 1'b1;
    tick();
    do_start(2'd1, 8'h00, 16'd2);
    vectors++;
    if (gc_data !== 32'h02030100 || gc_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL async_restart: got %h v=%b, want 02030100 v=1", gc_data, gc_valid);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_ramp_burst();
    test_ramp_wrap();
    test_const_stall();
    test_prbs_flush();
    test_alt();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
